// File: rtl/oclib_reset_sequencer.sv
// Staged reset sequencer. Holds all downstream resets for AssertCycles, releases them
// one by one every StageGap cycles, waits SettleCycles, then pulses resetDone.
module oclib_reset_sequencer #(
  parameter int AssertCycles = 16,
  parameter int Stages       = 3,
  parameter int StageGap     = 4,
  parameter int SettleCycles = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              resetRequest,
  output logic [Stages-1:0] resetOut,
  output logic              resetActive,
  output logic              resetDone
);

  localparam int CntMax0 = (AssertCycles > StageGap) ? AssertCycles : StageGap;
  localparam int CntMax  = (CntMax0 > SettleCycles) ? CntMax0 : SettleCycles;
  localparam int CntW    = $clog2(CntMax + 1);
  localparam int SidxW   = $clog2(Stages + 1);

  localparam logic [CntW-1:0]  AssertLast = CntW'(AssertCycles - 1);
  localparam logic [CntW-1:0]  GapLast    = CntW'(StageGap - 1);
  localparam logic [CntW-1:0]  SettleLast = CntW'((SettleCycles > 0) ? SettleCycles - 1 : 0);
  localparam logic [SidxW-1:0] LastStage  = SidxW'(Stages - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE,
    SETTLE
  } state_t;

  state_t           state;
  logic [CntW-1:0]  cnt;
  logic [SidxW-1:0] stage;  // number of stages already released

  // NOTE: all state and outputs live in one clocked block using non-blocking
  // assignments, so every output is a flop and reads see last cycle's values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ASSERT;
      cnt         <= '0;
      stage       <= '0;
      resetOut    <= '1;
      resetActive <= 1'b1;
      resetDone   <= 1'b0;
    end else begin
      resetDone <= 1'b0;
      if (resetRequest) begin
        // A request restarts assertion from any state, including IDLE.
        state       <= ASSERT;
        cnt         <= '0;
        stage       <= '0;
        resetOut    <= '1;
        resetActive <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            resetOut    <= '0;
            resetActive <= 1'b0;
          end

          ASSERT: begin
            if (cnt == AssertLast) begin
              cnt      <= '0;
              stage    <= SidxW'(1);
              resetOut <= ~Stages'(1);
              if (Stages > 1) begin
                state <= RELEASE;
              end else if (SettleCycles > 0) begin
                state <= SETTLE;
              end else begin
                state       <= IDLE;
                resetActive <= 1'b0;
                resetDone   <= 1'b1;
              end
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end

          RELEASE: begin
            if (cnt == GapLast) begin
              cnt      <= '0;
              stage    <= stage + SidxW'(1);
              resetOut <= resetOut & ~(Stages'(1) << stage);
              if (stage == LastStage) begin
                // The cycle the final stage drops is already the first settle cycle.
                if (SettleCycles > 0) begin
                  state <= SETTLE;
                end else begin
                  state       <= IDLE;
                  resetActive <= 1'b0;
                  resetDone   <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end

          SETTLE: begin
            if (cnt == SettleLast) begin
              cnt         <= '0;
              state       <= IDLE;
              resetActive <= 1'b0;
              resetDone   <= 1'b1;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end

          default: begin
            state       <= ASSERT;
            cnt         <= '0;
            stage       <= '0;
            resetOut    <= '1;
            resetActive <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Directed bench for oclib_reset_sequencer with AssertCycles=4, Stages=3, StageGap=2,
// SettleCycles=3: a per-cycle vector table plus hand-written abort/reset sequences.
module tb_oclib_reset_sequencer;

  localparam int AssertCycles = 4;
  localparam int Stages       = 3;
  localparam int StageGap     = 2;
  localparam int SettleCycles = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              resetRequest = 1'b0;
  logic [Stages-1:0] resetOut;
  logic              resetActive;
  logic              resetDone;

  always #5 clock = ~clock;

  oclib_reset_sequencer #(
    .AssertCycles(AssertCycles),
    .Stages      (Stages),
    .StageGap    (StageGap),
    .SettleCycles(SettleCycles)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .resetRequest(resetRequest),
    .resetOut    (resetOut),
    .resetActive (resetActive),
    .resetDone   (resetDone)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic [2:0] out;
    logic       act;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic req, input logic [2:0] out,
                     input logic act, input logic done, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{rst, req, out, act, done});
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got out=%b act=%b done=%b, expected out=%b act=%b done=%b",
               name, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Inputs are held for the current cycle; outputs are sampled mid-cycle.
  task automatic step(input string name, input logic rst, input logic req,
                      input logic [4:0] exp);
    reset        = rst;
    resetRequest = req;
    @(negedge clock);
    check(name, {resetOut, resetActive, resetDone}, exp);
    @(posedge clock);
    #1;
  endtask

  // Expected {resetOut, resetActive, resetDone} c cycles into an undisturbed sequence.
  function automatic logic [4:0] model(input int c);
    if (c < 4)       return {3'b111, 1'b1, 1'b0};
    else if (c < 6)  return {3'b110, 1'b1, 1'b0};
    else if (c < 8)  return {3'b100, 1'b1, 1'b0};
    else if (c < 11) return {3'b000, 1'b1, 1'b0};
    else if (c == 11) return {3'b000, 1'b0, 1'b1};
    else             return {3'b000, 1'b0, 1'b0};
  endfunction

  initial begin
    // Reset held with a request present: request ignored, reset state visible.
    add(1, 1, 3'b111, 1, 0, 2);
    // Power-on sequence, cycles 0..12.
    add(0, 0, 3'b111, 1, 0, 4);
    add(0, 0, 3'b110, 1, 0, 2);
    add(0, 0, 3'b100, 1, 0, 2);
    add(0, 0, 3'b000, 1, 0, 3);
    add(0, 0, 3'b000, 0, 1, 1);
    add(0, 0, 3'b000, 0, 0, 1);
    // One-cycle request from IDLE at cycle 13; done at 25.
    add(0, 1, 3'b000, 0, 0, 1);
    add(0, 0, 3'b111, 1, 0, 4);
    add(0, 0, 3'b110, 1, 0, 2);
    add(0, 0, 3'b100, 1, 0, 2);
    add(0, 0, 3'b000, 1, 0, 3);
    // Request in the done cycle starts a new sequence at 26.
    add(0, 1, 3'b000, 0, 1, 1);
    // Requests at ASSERT cycles 2 and 5 extend assertion to 10 cycles.
    add(0, 0, 3'b111, 1, 0, 2);
    add(0, 1, 3'b111, 1, 0, 1);
    add(0, 0, 3'b111, 1, 0, 2);
    add(0, 1, 3'b111, 1, 0, 1);
    add(0, 0, 3'b111, 1, 0, 4);
    add(0, 0, 3'b110, 1, 0, 2);
    add(0, 0, 3'b100, 1, 0, 2);
    add(0, 0, 3'b000, 1, 0, 3);
    add(0, 0, 3'b000, 0, 1, 1);
    add(0, 0, 3'b000, 0, 0, 2);

    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("table[%0d]", i), vecs[i].rst, vecs[i].req,
           {vecs[i].out, vecs[i].act, vecs[i].done});

    // Abort while resetOut=100: full restart, no done for the aborted run.
    step("abort_rst", 1'b1, 1'b0, model(12));
    for (int c = 0; c < 7; c++) step($sformatf("abort_pre[%0d]", c), 1'b0, 1'b0, model(c));
    step("abort_req", 1'b0, 1'b1, model(7));
    for (int c = 0; c < 13; c++) step($sformatf("abort_post[%0d]", c), 1'b0, 1'b0, model(c));

    // Request in the last SETTLE cycle: ASSERT next, no done pulse.
    step("settle_rst", 1'b1, 1'b0, model(12));
    for (int c = 0; c < 10; c++) step($sformatf("settle_pre[%0d]", c), 1'b0, 1'b0, model(c));
    step("settle_req", 1'b0, 1'b1, model(10));
    for (int c = 0; c < 5; c++) step($sformatf("settle_post[%0d]", c), 1'b0, 1'b0, model(c));

    // Block reset mid-release (sequence cycle 5): all ones next cycle, no done.
    step("midrst_assert", 1'b1, 1'b0, model(5));
    for (int c = 0; c < 13; c++) step($sformatf("midrst_post[%0d]", c), 1'b0, 1'b0, model(c));

    // Held request keeps ASSERT indefinitely; release counts from the last request.
    step("held_start", 1'b0, 1'b1, model(12));
    for (int c = 0; c < 20; c++) step($sformatf("held[%0d]", c), 1'b0, 1'b1, model(0));
    for (int c = 0; c < 13; c++) step($sformatf("held_post[%0d]", c), 1'b0, 1'b0, model(c));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
